// File: rtl/add_share_arb.sv
// Round-robin arbiter time-sharing one external combinational 32-bit adder among NUM_REQ requesters.
// Optional ADD_ARB_OVF_EN adds a registered signed-overflow flag (rsp_ovf) alongside rsp_data.
module add_share_arb #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  input  logic [31:0]            add_sum,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [31:0]            rsp_data,
  output logic                   busy
`ifdef ADD_ARB_OVF_EN
  ,
  output logic                   rsp_ovf
`endif
);

  // state | meaning
  // IDLE  | arbitrating; winner accepted and operands latched this cycle
  // CALC  | adder driven from opa/opb; sum captured at end of cycle
  // RESP  | rsp_valid to grant until its rsp_ready
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, grant, win_idx, grant_inc;
  logic             win_found, rsp_done;
  logic [31:0]      opa, opb, win_a, win_b;
  int               pos;

  // First valid requester at or above rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    pos       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && req_valid[pos]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(pos);
      end
    end
  end

  assign win_a     = req_a[32*int'(win_idx) +: 32];
  assign win_b     = req_b[32*int'(win_idx) +: 32];
  assign rsp_done  = (state == RESP) && rsp_ready[grant];
  assign grant_inc = (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
  assign add_a     = opa;
  assign add_b     = opb;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = CALC;
      CALC:    state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are masked during reset so nothing is accepted or delivered.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state != IDLE);
    if (!rst && state == IDLE && win_found) req_ready[win_idx] = 1'b1;
    if (!rst && state == RESP)              rsp_valid[grant]   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      grant    <= '0;
      opa      <= '0;
      opb      <= '0;
      rsp_data <= '0;
    end else begin
      if (state == IDLE && win_found) begin
        grant <= win_idx;
        opa   <= win_a;
        opb   <= win_b;
      end
      if (state == CALC) rsp_data <= add_sum;
      if (rsp_done)      rr_ptr   <= grant_inc;
    end
  end

`ifdef ADD_ARB_OVF_EN
  always_ff @(posedge clk) begin
    if (rst)                rsp_ovf <= 1'b0;
    else if (state == CALC) rsp_ovf <= (opa[31] == opb[31]) && (add_sum[31] != opa[31]);
  end
`endif

endmodule
